// File: rtl/adc_clk_pkg.sv
// +--------------------------------------------------------------------------+
// | adc_clk_pkg : shared types and default parameters for adc_clk_gen        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package adc_clk_pkg;

  localparam int DEFAULT_N_CH  = 4;
  localparam int DEFAULT_DIV_W = 8;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } chan_state_e;

endpackage

`default_nettype wire

// File: rtl/adc_clk_chan.sv
// +--------------------------------------------------------------------------+
// | adc_clk_chan : per-channel gate FSM; burst counter when ADC_CLK_BURST_EN |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module adc_clk_chan
  import adc_clk_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rise_tick,
  input  logic             i_fall_tick,
  input  logic             i_ref,
  input  logic             i_ref_next,
  input  logic             i_req,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_burst_len,
  output logic             o_adc_clk,
  output logic             o_running,
  output logic             o_sample_stb,
  output logic             o_done
);

  chan_state_e state_q, state_d;
  logic        adc_clk_q, adc_clk_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic        burst_end;

`ifdef ADC_CLK_BURST_EN
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rises_q, rises_d;

  assign burst_end = (len_q != '0) && (rises_q == len_q);
`else
  logic unused_burst_len;

  assign unused_burst_len = ^i_burst_len;
  assign burst_end        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      adc_clk_q <= 1'b0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef ADC_CLK_BURST_EN
      len_q     <= '0;
      rises_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      adc_clk_q <= adc_clk_d;
      stb_q     <= stb_d;
      done_q    <= done_d;
`ifdef ADC_CLK_BURST_EN
      len_q     <= len_d;
      rises_q   <= rises_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_req && !i_stop) state_d = ST_ARM;
      ST_ARM: begin
        if (i_stop)           state_d = ST_IDLE;
        else if (i_rise_tick) state_d = ST_RUN;
      end
      // A stop landing on the closing fall edge needs no drain phase.
      ST_RUN: begin
        if (i_stop)                        state_d = (i_ref && !i_fall_tick) ? ST_DRAIN : ST_IDLE;
        else if (i_fall_tick && burst_end) state_d = ST_IDLE;
      end
      ST_DRAIN: if (i_fall_tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    adc_clk_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) && i_ref_next;
    stb_d     = i_fall_tick && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    done_d    = (state_q == ST_RUN) && !i_stop && i_fall_tick && burst_end;
`ifdef ADC_CLK_BURST_EN
    len_d   = len_q;
    rises_d = rises_q;
    if ((state_q == ST_ARM) && (state_d == ST_RUN)) begin
      len_d   = i_burst_len;
      rises_d = CNT_W'(1);
    end else if ((state_q == ST_RUN) && i_rise_tick && (len_q != '0) && (rises_q != len_q)) begin
      rises_d = rises_q + CNT_W'(1);
    end
`endif
  end

  assign o_adc_clk    = adc_clk_q;
  assign o_running    = (state_q != ST_IDLE);
  assign o_sample_stb = stb_q;
  assign o_done       = done_q;

endmodule

`default_nettype wire

// File: rtl/adc_clk_gen.sv
// +--------------------------------------------------------------------------+
// | adc_clk_gen : shared divider plus N_CH gated, glitch-free ADC clocks     |
// | Burst mode enabled by ADC_CLK_BURST_EN.                  Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module adc_clk_gen
  import adc_clk_pkg::*;
#(
  parameter int N_CH  = DEFAULT_N_CH,
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_200MHz_i,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div_i,
  input  logic [N_CH-1:0]  req_i,
  input  logic [N_CH-1:0]  stop_i,
  input  logic [CNT_W-1:0] burst_len_i,
  output logic [N_CH-1:0]  adc_clk_o,
  output logic [N_CH-1:0]  running_o,
  output logic [N_CH-1:0]  sample_stb_o,
  output logic [N_CH-1:0]  done_o
);

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             ref_q, ref_d;
  logic [DIV_W-1:0] div_sat;
  logic             wrap;
  logic             rise_tick;
  logic             fall_tick;

  assign clk     = clk_200MHz_i;
  assign rst     = ~reset_n;
  assign div_sat = (div_i == '0) ? DIV_W'(1) : div_i;

  // The half-period is sampled only at wrap so a div_i change never cuts a phase short.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ref_q <= 1'b0;
      per_q <= div_sat;
    end else begin
      cnt_q <= cnt_d;
      ref_q <= ref_d;
      per_q <= per_d;
    end
  end

  always_comb begin
    wrap      = (cnt_q == (per_q - DIV_W'(1)));
    cnt_d     = wrap ? '0 : (cnt_q + DIV_W'(1));
    ref_d     = ref_q ^ wrap;
    per_d     = wrap ? div_sat : per_q;
    rise_tick = wrap && !ref_q;
    fall_tick = wrap && ref_q;
  end

  generate
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
      adc_clk_chan #(
        .CNT_W (CNT_W)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .i_rise_tick  (rise_tick),
        .i_fall_tick  (fall_tick),
        .i_ref        (ref_q),
        .i_ref_next   (ref_d),
        .i_req        (req_i[ch]),
        .i_stop       (stop_i[ch]),
        .i_burst_len  (burst_len_i),
        .o_adc_clk    (adc_clk_o[ch]),
        .o_running    (running_o[ch]),
        .o_sample_stb (sample_stb_o[ch]),
        .o_done       (done_o[ch])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/adc_clk_gen.md
ADC_CLK_GEN -- requirements
Module: adc_clk_gen

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent ADC clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, width of half-period divider value.
REQ-003 SHALL have parameter CNT_W, default 16, width of burst pulse counter.
REQ-004 SHALL have port clk_200MHz_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port div_i  input  DIV_W  half-period in clk cycles, shared by all channels.
REQ-007 SHALL have port req_i  input  N_CH  per-channel start request, level-sampled each cycle.
REQ-008 SHALL have port stop_i  input  N_CH  per-channel stop request, level-sampled each cycle.
REQ-009 SHALL have port burst_len_i  input  CNT_W  pulses per burst (burst build only).
REQ-010 SHALL have port adc_clk_o  output  N_CH  registered gated ADC clocks.
REQ-011 SHALL have port running_o  output  N_CH  high while channel is not IDLE.
REQ-012 SHALL have port sample_stb_o  output  N_CH  one-cycle strobe on each adc_clk_o falling edge.
REQ-013 SHALL have port done_o  output  N_CH  one-cycle pulse when a burst completes.

Function
REQ-014 SHALL run one shared divider: counter 0..D-1, D = max(div_i,1), latched only at counter wrap; reference phase ref toggles at each wrap; ADC clock period = 2*D cycles (D=20 gives 5 MHz).
REQ-015 SHALL generate rise_tick (wrap with ref 0->1) and fall_tick (wrap with ref 1->0) as internal one-cycle strobes.
REQ-016 SHALL hold per-channel FSM states IDLE, ARM, RUN, DRAIN.
REQ-017 IDLE: req_i=1 and stop_i=0 -> ARM; adc_clk_o=0.
REQ-018 ARM: stop_i=1 -> IDLE; rise_tick -> RUN with adc_clk_o=1 in that same registered cycle; no partial pulse ever emitted.
REQ-019 RUN: adc_clk_o follows ref; stop_i=1 with ref low -> IDLE next cycle; stop_i=1 with ref high -> DRAIN.
REQ-020 DRAIN: adc_clk_o follows ref until fall_tick, then IDLE; every high pulse SHALL be exactly D cycles wide.
REQ-021 Simultaneous req_i and stop_i SHALL resolve as stop; req_i in ARM/RUN/DRAIN SHALL be ignored.
REQ-022 sample_stb_o SHALL pulse on fall_tick in RUN or DRAIN only.
REQ-023 running_o SHALL be 1 in ARM, RUN, DRAIN.
REQ-024 div_i change mid-period SHALL take effect only at next wrap; no output pulse shorter than min(old D,new D).
REQ-025 Channels SHALL be mutually independent and phase-aligned to the shared ref.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force all FSMs IDLE, divider count 0, ref 0, burst counters 0, all outputs 0 on that edge, including mid-pulse.
REQ-027 First rise_tick after reset release SHALL occur D cycles after release.

Configuration
REQ-028 Macro ADC_CLK_BURST_EN SHALL enable burst mode: at ARM->RUN latch burst_len_i; count rising edges; after the Nth rise, next fall_tick -> IDLE with done_o pulse same cycle; burst_len_i=0 means continuous; stop_i still aborts without done_o.
REQ-029 Without ADC_CLK_BURST_EN, burst_len_i SHALL be ignored, burst counter absent, done_o tied 0; channels run until stop_i.

Structure
REQ-030 Shared package adc_clk_pkg SHALL hold FSM state enum and default parameter constants.
REQ-031 SHALL use one sub-module adc_clk_chan (per-channel FSM, gate, burst counter), instantiated N_CH times; divider stays in top.

Verification
REQ-032 D=20, req_i[0] pulse at cycle 5 after reset -> first adc_clk_o[0] rise at cycle 20, period 40, high 20 cycles.
REQ-033 Running channel, stop_i asserted while adc_clk_o high -> pulse completes full 20 cycles, then IDLE, running_o=0.
REQ-034 Burst build, burst_len_i=3 -> exactly 3 pulses, 3 sample_stb_o, done_o once on 3rd fall; burst_len_i=0 -> continuous.
REQ-035 div_i 20->5 mid-high phase -> current phase ends at 20, subsequent half-periods 5, no runt.
REQ-036 reset_n low during high phase -> all adc_clk_o 0 on that edge; req_i and stop_i same cycle -> channel stays IDLE.
